// File: rtl/mano_core_param.sv
// mano_core_param: parametrised accumulator CPU with embedded control
// sequencer, word-addressed memory and a load/readback port.
`timescale 1ns/1ps
module mano_core_param #(
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic              LD_EN,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [ADDR_W+3:0] LD_DATA,
    output logic [ADDR_W+3:0] RD_DATA,
    output logic [ADDR_W+3:0] AC,
    output logic              E,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W+3:0] IR,
    output logic [2:0]        SC,
    output logic              RUN,
    output logic              HALT
);

    localparam int DATA_W = ADDR_W + 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } sc_e;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_REG = 3'd7
    } op_e;

    sc_e               sc_q, sc_d;
    logic [ADDR_W-1:0] ar_q, ar_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              e_q, e_d;
    logic              i_q, i_d;
    logic              run_q, run_d;
    logic              halt_q, halt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_ar;
    logic [DATA_W:0]   sum;
    op_e               op;

    assign mem_ar  = mem_q[ar_q];
    assign RD_DATA = mem_q[LD_ADDR];
    assign op      = op_e'(ir_q[DATA_W-2 -: 3]);
    assign sum     = {1'b0, ac_q} + {1'b0, dr_q};

    always_comb begin
        sc_d      = sc_q;
        ar_d      = ar_q;
        pc_d      = pc_q;
        dr_d      = dr_q;
        ac_d      = ac_q;
        ir_d      = ir_q;
        e_d       = e_q;
        i_d       = i_q;
        run_d     = run_q;
        halt_d    = halt_q;
        mem_we    = 1'b0;
        mem_waddr = ar_q;
        mem_wdata = ac_q;
        if (!run_q) begin
            // a load in the START cycle lands before the first fetch
            if (LD_EN) begin
                mem_we    = 1'b1;
                mem_waddr = LD_ADDR;
                mem_wdata = LD_DATA;
            end
            if (START) begin
                run_d  = 1'b1;
                halt_d = 1'b0;
                sc_d   = T0;
            end
        end else begin
            unique case (sc_q)
                T0: begin
                    ar_d = pc_q;
                    sc_d = T1;
                end
                T1: begin
                    ir_d = mem_ar;
                    pc_d = pc_q + 1'b1;
                    sc_d = T2;
                end
                T2: begin
                    ar_d = ir_q[ADDR_W-1:0];
                    i_d  = ir_q[DATA_W-1];
                    sc_d = T3;
                end
                T3: begin
                    if (op != OP_REG) begin
                        if (i_q) ar_d = mem_ar[ADDR_W-1:0];
                        sc_d = T4;
                    end else begin
                        sc_d = T0;
                        if (!i_q) begin
                            unique case (ir_q[3:0])
                                4'd0:  ac_d = '0;
                                4'd1:  e_d = 1'b0;
                                4'd2:  ac_d = ~ac_q;
                                4'd3:  e_d = ~e_q;
                                4'd4:  {ac_d, e_d} = {e_q, ac_q};
                                4'd5:  {e_d, ac_d} = {ac_q, e_q};
                                4'd6:  ac_d = ac_q + 1'b1;
                                4'd7:  if (!ac_q[DATA_W-1]) pc_d = pc_q + 1'b1;
                                4'd8:  if (ac_q[DATA_W-1]) pc_d = pc_q + 1'b1;
                                4'd9:  if (ac_q == '0) pc_d = pc_q + 1'b1;
                                4'd10: if (!e_q) pc_d = pc_q + 1'b1;
                                4'd11: begin
                                    run_d  = 1'b0;
                                    halt_d = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                T4: begin
                    sc_d = T5;
                    unique case (op)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: dr_d = mem_ar;
                        OP_STA: begin
                            mem_we = 1'b1;
                            sc_d   = T0;
                        end
                        OP_BUN: begin
                            pc_d = ar_q;
                            sc_d = T0;
                        end
                        OP_BSA: begin
                            mem_we    = 1'b1;
                            mem_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
                            ar_d      = ar_q + 1'b1;
                        end
                        default: sc_d = T0;
                    endcase
                end
                T5: begin
                    sc_d = T0;
                    unique case (op)
                        OP_AND: ac_d = ac_q & dr_q;
                        OP_ADD: {e_d, ac_d} = sum;
                        OP_LDA: ac_d = dr_q;
                        OP_BSA: pc_d = ar_q;
                        OP_ISZ: begin
                            dr_d = dr_q + 1'b1;
                            sc_d = T6;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    mem_we    = 1'b1;
                    mem_wdata = dr_q;
                    if (dr_q == '0) pc_d = pc_q + 1'b1;
                    sc_d = T0;
                end
                default: sc_d = T0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sc_q   <= T0;
            ar_q   <= '0;
            pc_q   <= '0;
            dr_q   <= '0;
            ac_q   <= '0;
            ir_q   <= '0;
            e_q    <= 1'b0;
            i_q    <= 1'b0;
            run_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            sc_q   <= sc_d;
            ar_q   <= ar_d;
            pc_q   <= pc_d;
            dr_q   <= dr_d;
            ac_q   <= ac_d;
            ir_q   <= ir_d;
            e_q    <= e_d;
            i_q    <= i_d;
            run_q  <= run_d;
            halt_q <= halt_d;
        end
    end

    // CLR forces run_q low, so no processor write can complete under reset
    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign AC   = ac_q;
    assign E    = e_q;
    assign PC   = pc_q;
    assign IR   = ir_q;
    assign SC   = sc_q;
    assign RUN  = run_q;
    assign HALT = halt_q;

endmodule

// File: doc/mano_core_param.md
# mano_core_param

Parametrised successor to the fixed 8-bit basic-computer top. A self-contained accumulator CPU holds AR, PC, DR, AC, IR, E, the sequence counter, instruction memory and an embedded control FSM. It widens the original AND/ADD/LDA/COM set to the full memory-reference and register-reference instruction set, plus indirect addressing, halt/restart and a memory load/readback port. It is the single top-level processor used by the FPGA and simulation benches.

## Interface
- ADDR_W, 4: address width; memory depth 2^ADDR_W words; must be ≥4.
- DATA_W, ADDR_W+4: word width; fixed relation, not independently overridable.
- CLK  in  1  rising-edge clock.
- CLR  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; begins execution at current PC when not running.
- LD_EN  in  1  memory write from load port; honoured only while RUN=0.
- LD_ADDR  in  ADDR_W  load/readback address.
- LD_DATA  in  DATA_W  load data.
- RD_DATA  out  DATA_W  combinational M[LD_ADDR].
- AC  out  DATA_W  accumulator.
- E  out  1  carry/extend flag.
- PC  out  ADDR_W  program counter.
- IR  out  DATA_W  instruction register.
- SC  out  3  sequence counter (T0..T6).
- RUN  out  1  executing.
- HALT  out  1  stopped by HLT instruction.

## Operation
- Instruction word: [DATA_W-1]=I (indirect), [DATA_W-2:DATA_W-4]=opcode D, [ADDR_W-1:0]=address.
- Memory: 2^ADDR_W×DATA_W array, synchronous write, combinational read. Not cleared by CLR.
- PC stored to memory is zero-extended; AR/PC loads from data use the low ADDR_W bits.
- Fetch: T0 AR←PC; T1 IR←M[AR], PC←PC+1; T2 AR←IR address, latch I, decode D.
- D=0..6: T3 AR←M[AR] if I=1, otherwise idle.
- AND: T4 DR←M[AR]; T5 AC←AC&DR.
- ADD: T4 DR←M[AR]; T5 {E,AC}←AC+DR (DATA_W+1-bit sum).
- LDA: T4 DR←M[AR]; T5 AC←DR.
- STA: T4 M[AR]←AC.
- BUN: T4 PC←AR.
- BSA: T4 M[AR]←PC, AR←AR+1; T5 PC←AR.
- ISZ: T4 DR←M[AR]; T5 DR←DR+1 (wraps); T6 M[AR]←DR, and PC←PC+1 if DR==0.
- The final step of every instruction sets SC←0.
- D=7, I=0 is register-reference, executed at T3 then SC←0. Select = IR[3:0]:
  - 0 CLA, 1 CLE, 2 CMA, 3 CME.
  - 4 CIR: {AC,E}←{E,AC} rotate right through E.
  - 5 CIL: {E,AC}←{AC,E} rotate left through E.
  - 6 INC: AC+1, E unchanged.
  - 7 SPA, 8 SNA, 9 SZA, 10 SZE: skip = PC+1 on AC msb=0 / msb=1 / AC==0 / E==0.
  - 11 HLT: RUN←0, HALT←1.
  - 12–15 NOP.
- D=7, I=1: NOP, SC←0 at T3.
- PC arithmetic wraps modulo 2^ADDR_W.

## Timing
- CLR asserted, including mid-instruction: immediately sets AR, PC, DR, AC, IR, E, SC, RUN and HALT to 0. Memory is retained. Any write in progress is abandoned and no partial update occurs.
- START with RUN=0: next edge RUN←1, HALT←0, SC←0. The first fetch T0 occurs on the following edge. START while RUN=1 is ignored.
- SC advances only while RUN=1; frozen otherwise.
- Instruction cycle counts (T0 to SC=0):
  - register-ref / HLT / D7-I1: 4
  - BUN, STA: 5
  - AND, ADD, LDA, BSA: 6
  - ISZ: 7
  - The T3 cycle is always spent, even when I=0.
- LD_EN together with RUN=1: write dropped. LD_EN in the same cycle as START: write performed, then start.
- HLT edge: RUN falls on the same edge SC clears. PC already points past the HLT.

## Test plan
- Arithmetic program. Load M0=0x28 LDA 8, M1=0x19 ADD 9, M2=0x3A STA 10, M3=0x7B HLT, M8=0x05, M9=0xFE; pulse START -> after 21 run cycles AC=0x03, E=1, M10=0x03, PC=4, HALT=1.
- Indirect load. M0=0xA8, M8=0x09, M9=0x77, M1=0x7B -> AC=0x77; LDA takes 6 cycles.
- ISZ skip. M0=0x6F, M15=0xFF, M2=0x7B -> M15=0x00, PC skips to 2, halts with PC=3. Repeat with M15=0x10 -> M15=0x11, M1=0x7B executes.
- BSA/BUN. M0=0x5C, M13=0x7B -> M12=0x01, PC=13, then HALT with PC=14.
- Register ops. AC=0x81 (via LDA) then CIL 0x75 -> AC=0x02, E=1. Then CIR 0x74 -> AC=0x81, E=0. Then SNA 0x78 skips the next word.
- Reset and guards. Assert CLR at SC=4 of STA -> all outputs 0 and target memory unchanged. LD_EN while RUN=1 -> RD_DATA unchanged.
